// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared widths, defaults and segment encoding for the CAN bit timing block
package can_pkg;
    localparam int DEF_BRP_W       = 6;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_IDLE_BITS   = 11;
    localparam int TSEG1_W         = 4;
    localparam int TSEG2_W         = 3;
    localparam int SJW_W           = 2;
    localparam int SEG_CNT_W       = 5;

    typedef enum logic [1:0] {
        SYNC_SEG = 2'd0,
        TSEG1    = 2'd1,
        TSEG2    = 2'd2
    } seg_e;
endpackage

// File: rtl/can_rx_sync.sv
// rtl/can_rx_sync.sv - CAN RX pin synchroniser with recessive-to-dominant edge pulse
module can_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic can_rx,
    output logic rx_s,
    output logic rx_fall
);
    logic [STAGES-1:0] chain;
    logic              rx_prev;

    // The bus idles recessive, so the chain resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain   <= '1;
            rx_prev <= 1'b1;
        end else begin
            chain   <= {chain[STAGES-2:0], can_rx};
            rx_prev <= chain[STAGES-1];
        end
    end

    assign rx_s    = chain[STAGES-1];
    assign rx_fall = rx_prev & ~rx_s;
endmodule

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - CAN bit timing, hard/soft synchronisation and bit sampling front end
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP_W       = DEF_BRP_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int IDLE_BITS   = DEF_IDLE_BITS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               can_rx,
    input  logic [BRP_W-1:0]   cfg_brp,
    input  logic [TSEG1_W-1:0] cfg_tseg1,
    input  logic [TSEG2_W-1:0] cfg_tseg2,
    input  logic [SJW_W-1:0]   cfg_sjw,
    output logic               rx_bit,
    output logic               sample_point,
    output logic               bit_start,
    output logic               bus_idle
);
    localparam int                IDLE_W   = $clog2(IDLE_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_BITS);

    logic                 rx_s;
    logic                 rx_fall;
    logic [BRP_W-1:0]     brp_l, brp_cnt, brp_cnt_n;
    logic [TSEG1_W-1:0]   tseg1_l;
    logic [TSEG2_W-1:0]   tseg2_l, t2_eff, t2_n, t2_rem;
    logic [SJW_W-1:0]     sjw_l;
    logic [2:0]           sjw_tq, ext;
    logic [SEG_CNT_W-1:0] seg_cnt, seg_cnt_n, t1_eff, t1_n, phase_err;
    logic [IDLE_W-1:0]    idle_cnt, idle_n;
    seg_e                 seg, seg_n;
    logic                 resync_done, done_n;
    logic                 tq_tick, honoured, jump, take_sample, enter_sync;

    can_rx_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
        .clock   (clock),
        .reset   (reset),
        .can_rx  (can_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign tq_tick   = (brp_cnt == brp_l);
    assign honoured  = rx_fall & rx_bit & ~resync_done;
    assign sjw_tq    = {1'b0, sjw_l} + 3'd1;
    assign phase_err = seg_cnt + 5'd1;
    assign ext       = (phase_err > {2'b00, sjw_tq}) ? sjw_tq : phase_err[2:0];
    assign t2_rem    = t2_eff - seg_cnt[2:0];
    assign idle_n    = !rx_s ? '0 : (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;

    always_comb begin
        seg_n       = seg;
        seg_cnt_n   = seg_cnt;
        brp_cnt_n   = tq_tick ? '0 : brp_cnt + 1'b1;
        t1_n        = t1_eff;
        t2_n        = t2_eff;
        done_n      = resync_done;
        jump        = 1'b0;
        take_sample = 1'b0;
        enter_sync  = 1'b0;

        if (honoured) begin
            done_n = 1'b1;
            if (bus_idle) begin
                jump = 1'b1;
                t1_n = {1'b0, tseg1_l};
                t2_n = tseg2_l;
            end else if (seg == TSEG1) begin
                t1_n = {1'b0, tseg1_l} + {2'b00, ext};
            end else if (seg == TSEG2) begin
                if (t2_rem <= sjw_tq) jump = 1'b1;
                else                  t2_n = t2_eff - sjw_tq;
            end
        end

        // A repositioning edge overrides the tick; length adjustments feed this cycle's compare.
        if (jump) begin
            seg_n     = TSEG1;
            seg_cnt_n = '0;
            brp_cnt_n = '0;
        end else if (tq_tick) begin
            case (seg)
                SYNC_SEG: begin
                    seg_n     = TSEG1;
                    seg_cnt_n = '0;
                end
                TSEG1: begin
                    if (seg_cnt == t1_n) begin
                        seg_n       = TSEG2;
                        seg_cnt_n   = '0;
                        take_sample = 1'b1;
                    end else begin
                        seg_cnt_n = seg_cnt + 5'd1;
                    end
                end
                TSEG2: begin
                    if (seg_cnt == {2'b00, t2_n}) begin
                        seg_n      = SYNC_SEG;
                        seg_cnt_n  = '0;
                        enter_sync = 1'b1;
                    end else begin
                        seg_cnt_n = seg_cnt + 5'd1;
                    end
                end
                default: seg_n = SYNC_SEG;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            brp_l        <= cfg_brp;
            tseg1_l      <= cfg_tseg1;
            tseg2_l      <= cfg_tseg2;
            sjw_l        <= cfg_sjw;
            t1_eff       <= {1'b0, cfg_tseg1};
            t2_eff       <= cfg_tseg2;
            seg          <= SYNC_SEG;
            seg_cnt      <= '0;
            brp_cnt      <= '0;
            resync_done  <= 1'b0;
            rx_bit       <= 1'b1;
            sample_point <= 1'b0;
            bit_start    <= 1'b0;
            idle_cnt     <= IDLE_MAX;
            bus_idle     <= 1'b1;
        end else begin
            seg          <= seg_n;
            seg_cnt      <= seg_cnt_n;
            brp_cnt      <= brp_cnt_n;
            sample_point <= take_sample;
            bit_start    <= enter_sync;
            if (enter_sync) begin
                brp_l       <= cfg_brp;
                tseg1_l     <= cfg_tseg1;
                tseg2_l     <= cfg_tseg2;
                sjw_l       <= cfg_sjw;
                t1_eff      <= {1'b0, cfg_tseg1};
                t2_eff      <= cfg_tseg2;
                resync_done <= 1'b0;
            end else begin
                t1_eff      <= t1_n;
                t2_eff      <= t2_n;
                resync_done <= done_n;
            end
            if (take_sample) begin
                rx_bit   <= rx_s;
                idle_cnt <= idle_n;
                bus_idle <= (idle_n == IDLE_MAX);
            end
        end
    end
endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Bit-timing and sampling front end for the CAN receive path. It sits directly upstream of the frame decoder FSM.
- Synchronises the raw CAN RX pin and divides the clock into time quanta (tq).
- Performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges.
- Produces the `rx_bit` / `sample_point` pair consumed by the decoder, plus a bus-idle indication.

Parameters:
- BRP_W, 6, width of the baud-rate prescaler config.
- SYNC_STAGES, 2, flip-flop stages in the `can_rx` synchroniser (min 2).
- IDLE_BITS, 11, consecutive recessive samples needed to declare bus idle.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- can_rx  in  1  raw CAN RX pin, asynchronous; 1 = recessive.
- cfg_brp  in  BRP_W  tq = (cfg_brp+1) clocks.
- cfg_tseg1  in  4  PROP+PHASE1 length = cfg_tseg1+1 tq.
- cfg_tseg2  in  3  PHASE2 length = cfg_tseg2+1 tq.
- cfg_sjw  in  2  resync jump width = cfg_sjw+1 tq.
- rx_bit  out  1  last sampled bus value, held between samples.
- sample_point  out  1  one-clock pulse; `rx_bit` is valid and new in the same cycle.
- bit_start  out  1  one-clock pulse at entry to SYNC_SEG (reserved for a future transmitter).
- bus_idle  out  1  high after IDLE_BITS consecutive recessive samples.

Behaviour:
- Reset: all state cleared on the clock edge where reset=1.
  - Synchroniser chain = 1, rx_bit=1, sample_point=0, bit_start=0, bus_idle=1.
  - Idle counter = IDLE_BITS, segment = SYNC_SEG, brp_cnt=0, seg_cnt=0, resync_done=0.
  - Config registers are latched from the cfg_* inputs.
  - Reset mid-bit discards the bit in progress; no sample_point pulse is emitted.
- Synchroniser: `rx_s` is the output of SYNC_STAGES flip-flops. `rx_prev` is `rx_s` delayed one clock.
- Edge detection: `edge = rx_prev & ~rx_s`, i.e. recessive-to-dominant only. The edge is honoured only if rx_bit==1 (last sample recessive) and resync_done==0.
- Prescaler: brp_cnt counts 0..brp_l. `tq_tick` is asserted when brp_cnt==brp_l, and brp_cnt then wraps to 0.
- Segment FSM (advances only on tq_tick unless an edge rule applies):
  - SYNC_SEG: one tq. On tq_tick → TSEG1, seg_cnt=0.
  - TSEG1: on tq_tick, if seg_cnt==t1_eff → TSEG2, seg_cnt=0, and fire the sample actions. Otherwise seg_cnt+1.
  - TSEG2: on tq_tick, if seg_cnt==t2_eff → SYNC_SEG, bit_start pulses. Otherwise seg_cnt+1.
- Sample actions: registered, so sample_point is high in the cycle after the qualifying tq_tick. In that same cycle rx_bit takes `rx_s` as captured at the tick.
- Effective segment lengths: t1_eff = tseg1_l + ext and t2_eff = tseg2_l. Both are reloaded at SYNC_SEG entry, with ext=0.
- Config latch: cfg_* are latched into brp_l / tseg1_l / tseg2_l / sjw_l only at SYNC_SEG entry and at reset. Changing cfg mid-bit has no effect until the next bit.
- Hard sync (edge while bus_idle=1):
  - Next cycle: segment=TSEG1, seg_cnt=0, brp_cnt=0, resync_done=1, t1_eff=tseg1_l, t2_eff=tseg2_l.
  - The edge tq counts as SYNC_SEG; no bit_start pulse is emitted.
- Resync (edge while bus_idle=0):
  - Edge in SYNC_SEG: no adjustment.
  - Edge in TSEG1, phase error e = seg_cnt+1: set ext = min(e, sjw_l+1).
  - Edge in TSEG2, remaining r = t2_eff - seg_cnt:
    - If r ≤ sjw_l+1: next cycle → TSEG1, seg_cnt=0, brp_cnt=0, no bit_start pulse.
    - Otherwise: t2_eff -= sjw_l+1.
  - Every honoured edge sets resync_done. resync_done clears at SYNC_SEG entry.
- Edge coinciding with tq_tick: the edge rule takes priority over normal advance.
- Bus idle: each sample_point with a recessive value increments the idle counter, saturating at IDLE_BITS; a dominant sample clears it to 0.
  - bus_idle = (count==IDLE_BITS), registered.
  - bus_idle falls in the same cycle as the sample_point that samples dominant.
- Width rules: all counters are unsigned. ext fits in 3 bits; t1_eff fits in 5 bits.

Decomposition:
- Shared package `can_pkg`:
  - Segment enum {SYNC_SEG, TSEG1, TSEG2}.
  - Config field widths (BRP_W, TSEG1_W=4, TSEG2_W=3, SJW_W=2).
  - IDLE_BITS default.
- One natural sub-module: `can_rx_sync`, the N-stage synchroniser plus `rx_prev` and the edge pulse. Everything else stays in `can_bit_timing`.

Test Plan:
- Hard sync, nominal timing (brp=1, tseg1=5, tseg2=2, sjw=0, bit = 20 clocks). Bus idle, `can_rx` falls; edge detected at cycle k → sample_point at k+13 with rx_bit=0, then k+33, k+53 with no further edges; bit_start at k+19.
- Late edge in TSEG1 (same config): edge detected with seg_cnt=1 (e=2) → ext=1 tq; that bit's sample_point is 2 clocks later than nominal; the following bit is back to nominal.
- Early edge in TSEG2 (sjw=1, tseg2=2): edge detected at seg_cnt=2 (r=0) → TSEG1 next cycle, brp_cnt=0; next sample_point 13 clocks after the edge-detect cycle.
- Second edge in the same bit, and edge while rx_bit=0: both ignored; sample_point timing unchanged.
- Bus idle: 11 recessive samples → bus_idle=1 at the 11th sample_point; one dominant sample clears it in the same cycle.
- Reset mid-TSEG1, and cfg_brp change mid-bit (1→3): reset → rx_bit=1, bus_idle=1, no pulse emitted; the brp change takes effect only after the next SYNC_SEG entry (tq becomes 4 clocks).
